// File: rtl/wb_defs.sv
// Shared Wishbone definitions: FSM state encoding plus default widths and
// the default timeout used by the command master and its timer.
package wb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int WB_ADR_WIDTH_DEF = 32;
  localparam int WB_DAT_WIDTH_DEF = 32;
  localparam int WB_TIMEOUT_DEF   = 255;
  localparam int WB_TIMER_W       = 16;
  localparam int WB_SEL_W         = 4;

endpackage

// File: rtl/wb_timeout.sv
// Strobe watchdog: counts bus cycles without ack and flags the cycle in which
// the count would reach the limit, so strobe stays high exactly limit cycles.
module wb_timeout
  import wb_defs::*;
#(
  parameter int timeout_cycles = WB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WB_TIMER_W-1:0] LAST = WB_TIMER_W'(timeout_cycles - 1);

  logic [WB_TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final permitted strobe cycle; the FSM leaves at this edge.
  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone classic master with strobe timeout.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module wb_cmd_master
  import wb_defs::*;
#(
  parameter int wb_adr_width   = WB_ADR_WIDTH_DEF,
  parameter int wb_dat_width   = WB_DAT_WIDTH_DEF,
  parameter int timeout_cycles = WB_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [wb_adr_width-1:0] cmd_adr_i,
  input  logic [wb_dat_width-1:0] cmd_dat_i,
  input  logic [3:0]              cmd_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [wb_dat_width-1:0] rsp_dat_o,
  output logic                    rsp_err_o,
  output logic [wb_adr_width-1:0] wb_adr_o,
  output logic [wb_dat_width-1:0] wb_dat_o,
  output logic                    wb_we_o,
  output logic [3:0]              wb_sel_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic [wb_dat_width-1:0] wb_dat_i,
  input  logic                    wb_ack_i
);

  wb_state_e               state_q, state_d;
  logic [wb_adr_width-1:0] adr_q, adr_d;
  logic [wb_dat_width-1:0] dat_q, dat_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [wb_dat_width-1:0] rsp_dat_q, rsp_dat_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    tmr_clear, tmr_enable, tmr_expired;

  wb_timeout #(.timeout_cycles(timeout_cycles)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          we_d      = cmd_we_i;
          sel_d     = cmd_sel_i;
          tmr_clear = 1'b1;
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (wb_ack_i) begin
          rsp_dat_d = we_q ? '0 : wb_dat_i;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_expired) begin
            rsp_dat_d = '0;
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = (state_q == ST_BUS);
  assign wb_stb_o    = (state_q == ST_BUS);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with timeout_cycles = 8; the slave is
// driven step by step from the main initial block.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic [3:0]  wb_sel_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .wb_adr_width   (32),
    .wb_dat_width   (32),
    .timeout_cycles (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one command, act as the slave (ack in strobe cycle ack_at, 0 = never),
  // then check the response, optionally holding rsp_ready_i low for hold cycles.
  task automatic run_txn(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                         input logic [31:0] rd_dat, input int exp_stb,
                         input logic [31:0] exp_rsp, input logic exp_err, input int hold);
    int n;
    check({name, "_cmd_ready_idle"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    tick;
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = ~adr;
    cmd_dat_i   = ~dat;
    cmd_sel_i   = ~sel;
    n = 0;
    while (wb_stb_o === 1'b1 && n < 50) begin
      n++;
      check({name, "_wb_adr"}, wb_adr_o, adr);
      check({name, "_wb_dat"}, wb_dat_o, dat);
      check({name, "_wb_we"}, 32'(wb_we_o), 32'(we));
      check({name, "_wb_sel"}, 32'(wb_sel_o), 32'(sel));
      check({name, "_wb_cyc"}, 32'(wb_cyc_o), 32'd1);
      check({name, "_cmd_ready_bus"}, 32'(cmd_ready_o), 32'd0);
      wb_ack_i = (n == ack_at);
      wb_dat_i = (n == ack_at) ? rd_dat : 32'hDEAD_BEEF;
      tick;
    end
    wb_ack_i = 1'b0;
    wb_dat_i = 32'hDEAD_BEEF;
    check({name, "_stb_cycles"}, 32'(n), 32'(exp_stb));
    check({name, "_cyc_after"}, 32'(wb_cyc_o), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    check({name, "_rsp_dat"}, rsp_dat_o, exp_rsp);
    check({name, "_rsp_err"}, 32'(rsp_err_o), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick;
      check({name, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
      check({name, "_hold_dat"}, rsp_dat_o, exp_rsp);
      check({name, "_hold_err"}, 32'(rsp_err_o), 32'(exp_err));
      check({name, "_hold_cmd_ready"}, 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;
    check({name, "_rsp_done"}, 32'(rsp_valid_o), 32'd0);
    check({name, "_cmd_ready_back"}, 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wb_dat_i    = 32'hDEAD_BEEF;
    wb_ack_i    = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);

    // Stray ack while idle must not produce a response.
    wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    check("idle_ack_ready", 32'(cmd_ready_o), 32'd1);
    check("idle_ack_valid", 32'(rsp_valid_o), 32'd0);
    check("idle_ack_stb", 32'(wb_stb_o), 32'd0);

    run_txn("rd",   1'b0, 32'h0,  32'h0,  4'hF, 2, 32'h0000_00A5, 2, 32'h0000_00A5, 1'b0, 0);
    run_txn("wr",   1'b1, 32'h4,  32'h3C, 4'hF, 2, 32'h1111_2222, 2, 32'h0,         1'b0, 0);
    run_txn("to",   1'b0, 32'h10, 32'h0,  4'h3, 0, 32'h5555_5555, 8, 32'h0,         1'b1, 0);
    run_txn("ack8", 1'b0, 32'h20, 32'h0,  4'h1, 8, 32'h1234_5678, 8, 32'h1234_5678, 1'b0, 0);
    run_txn("bp",   1'b0, 32'h8,  32'h0,  4'hC, 2, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 5);
    run_txn("wr1",  1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 4'h5, 1, 32'h7777_7777, 1, 32'h0, 1'b0, 0);

    // Reset in the middle of a bus cycle drops the transaction.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h40;
    cmd_sel_i   = 4'hF;
    tick;
    cmd_valid_i = 1'b0;
    check("mid_stb_before", 32'(wb_stb_o), 32'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    check("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_0BAD;
    tick;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      tick;
    end

    // Timer restarts cleanly after reset.
    run_txn("to2", 1'b0, 32'h44, 32'h0, 4'hF, 0, 32'h0, 8, 32'h0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameters SHALL be:
- wb_adr_width, 32, Wishbone address width.
- wb_dat_width, 32, Wishbone data width.
- timeout_cycles, 255, cycles strobe may stay high without ack; legal range 1..65535.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  wb_adr_width  byte address.
- cmd_dat_i  in  wb_dat_width  write data.
- cmd_sel_i  in  4  byte lane selects.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_dat_o  out  wb_dat_width  read data; 0 for writes and on timeout.
- rsp_err_o  out  1  1 = timeout abort.
- wb_adr_o  out  wb_adr_width  Wishbone address.
- wb_dat_o  out  wb_dat_width  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_dat_i  in  wb_dat_width  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE -> BUS -> RESP -> IDLE.
REQ-004 cmd_ready_o SHALL be high only in IDLE.
- On cmd_valid_i & cmd_ready_o, the command fields SHALL be registered.
- The FSM SHALL enter BUS at that edge.
REQ-005 In BUS, wb_cyc_o and wb_stb_o SHALL both be high.
- wb_adr_o, wb_dat_o, wb_we_o and wb_sel_o SHALL hold the registered command, stable for the whole cycle.
REQ-006 In BUS, when wb_ack_i is sampled high, the block SHALL act at that edge:
- Deassert wb_cyc_o and wb_stb_o.
- Capture wb_dat_i into rsp_dat_o for reads; set rsp_dat_o to 0 for writes.
- Clear rsp_err_o.
- Enter RESP.
REQ-007 A 16-bit counter SHALL clear on entry to BUS and increment on each BUS cycle without ack.
- When the counter reaches timeout_cycles, the block SHALL deassert wb_cyc_o and wb_stb_o, set rsp_dat_o = 0 and rsp_err_o = 1, and enter RESP.
- Strobe is therefore high for exactly timeout_cycles cycles.
REQ-008 If ack and timeout occur in the same cycle, ack SHALL win: rsp_err_o = 0.
REQ-009 wb_ack_i outside BUS SHALL be ignored.
REQ-010 In RESP, rsp_valid_o SHALL be high, with rsp_dat_o and rsp_err_o held stable.
- On rsp_ready_i, the FSM SHALL return to IDLE, so no command is accepted in the same cycle.
REQ-011 Latency against a registered-ack slave SHALL be as follows:
- Command accepted at edge 0.
- Strobe high from edge 0, ack seen at edge 2.
- rsp_valid_o high after edge 2.
REQ-012 At most one transaction SHALL be outstanding.
- Wishbone classic single cycles only: no bursts, no pipelining.

Reset
REQ-013 On rst, the FSM SHALL return to IDLE at the next edge, including mid-transaction; any pending response SHALL be discarded.
REQ-014 Reset values SHALL be:
- cmd_ready_o = 1 after reset.
- rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o = 0.
- rsp_dat_o, wb_adr_o, wb_dat_o, wb_sel_o = 0.
- Timeout counter = 0.

Structure
REQ-015 FSM state encodings and the default width and timeout constants SHALL reside in the shared Wishbone definitions package, wb_defs.
REQ-016 The timeout counter SHALL be a sub-module named wb_timeout, with inputs clear and enable and output expired.

Verification
REQ-017 Read, with a slave that acks one cycle after strobe: cmd adr 0x0, we 0 -> wb_stb_o high for 2 cycles, rsp_dat_o = 0x000000A5, rsp_err_o = 0.
REQ-018 Write: adr 0x4, dat 0x3C, sel 0xF -> wb_dat_o = 0x3C and wb_we_o = 1 while strobe is high; rsp_dat_o = 0, rsp_err_o = 0.
REQ-019 Timeout, with slave never acking and timeout_cycles = 8: wb_stb_o high exactly 8 cycles, then rsp_err_o = 1 and rsp_dat_o = 0.
REQ-020 Ack in the 8th cycle with timeout_cycles = 8 -> rsp_err_o = 0 and data captured.
REQ-021 Back-pressure: rsp_ready_i low for 5 cycles -> rsp_valid_o and data held, and cmd_ready_o low throughout.
REQ-022 rst asserted during BUS -> wb_cyc_o and wb_stb_o = 0 and cmd_ready_o = 1 after the next edge; no rsp_valid_o pulse.
